// File: rtl/seq_mult16_pkg.sv
// Shared ALU definitions for the sequential shift-add multiplier.
package seq_mult16_pkg;

    localparam int unsigned MUL_W = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2,
        ST_RSVD = 2'd3
    } mul_state_e;

endpackage

// File: rtl/seq_mult16_if.sv
// Start/busy/done handshake and operand/product bus of the MUL unit.
interface seq_mult16_if;
    import seq_mult16_pkg::*;

    logic                 start;
    logic [MUL_W-1:0]     a;
    logic [MUL_W-1:0]     b;
    logic                 busy;
    logic                 done;
    logic [2*MUL_W-1:0]   p;
    logic                 ovf;

    modport master (output start, a, b, input  busy, done, p, ovf);
    modport slave  (input  start, a, b, output busy, done, p, ovf);
endinterface

// File: rtl/seq_mult16_adder.sv
// Plain ripple-carry adder; the multiplier folds Sum/Cout back each cycle.
module seq_mult16_adder #(
    parameter int unsigned WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout
);
    logic [WIDTH:0] w_carry;

    assign w_carry[0] = i_cin;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign o_sum[i]       = i_a[i] ^ i_b[i] ^ w_carry[i];
        assign w_carry[i + 1] = (i_a[i] & i_b[i]) | (w_carry[i] & (i_a[i] ^ i_b[i]));
    end

    assign o_cout = w_carry[WIDTH];
endmodule

// File: rtl/seq_mult16.sv
// Sequential unsigned shift-add multiplier, one multiplier bit per cycle.
module seq_mult16
    import seq_mult16_pkg::*;
#(
    parameter int unsigned WIDTH = MUL_W,
    parameter int unsigned CNT_W = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_mult16_if.slave   bus
);
    mul_state_e       r_state, w_state_nxt;
    logic [CNT_W-1:0] r_count, w_count_nxt;
    logic [WIDTH-1:0] r_hi,    w_hi_nxt;
    logic [WIDTH-1:0] r_lo,    w_lo_nxt;
    logic [WIDTH-1:0] r_areg,  w_areg_nxt;
    logic             r_busy,  w_busy_nxt;
    logic             r_done,  w_done_nxt;
    logic             r_ovf,   w_ovf_nxt;

    logic [WIDTH-1:0] w_addend;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;

    // Multiplier LSB gates the multiplicand into the adder.
    assign w_addend = r_lo[0] ? r_areg : '0;

    seq_mult16_adder #(.WIDTH(WIDTH)) u_adder (
        .i_a    (r_hi),
        .i_b    (w_addend),
        .i_cin  (1'b0),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_count <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_areg  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_count <= w_count_nxt;
            r_hi    <= w_hi_nxt;
            r_lo    <= w_lo_nxt;
            r_areg  <= w_areg_nxt;
            r_busy  <= w_busy_nxt;
            r_done  <= w_done_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_count_nxt = r_count;
        w_hi_nxt    = r_hi;
        w_lo_nxt    = r_lo;
        w_areg_nxt  = r_areg;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_areg_nxt  = bus.a;
                    w_hi_nxt    = '0;
                    w_lo_nxt    = bus.b;
                    w_count_nxt = '0;
                    w_state_nxt = ST_CALC;
                end
            end
            ST_CALC: begin
                // Carry becomes the new MSB as the 33-bit {c,s,lo} shifts right.
                w_hi_nxt    = {w_cout, w_sum[WIDTH-1:1]};
                w_lo_nxt    = {w_sum[0], r_lo[WIDTH-1:1]};
                w_count_nxt = r_count + CNT_W'(1);
                if (r_count == CNT_W'(WIDTH - 1)) begin
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == ST_CALC) || (w_state_nxt == ST_DONE);
        w_done_nxt = (w_state_nxt == ST_DONE);
        w_ovf_nxt  = |w_hi_nxt;
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.p    = {r_hi, r_lo};
    assign bus.ovf  = r_ovf;
endmodule

// File: tb/tb_seq_mult16.sv
// Scoreboard bench for seq_mult16: directed corner cases plus random operands vs A*B.
module tb_seq_mult16;
    import seq_mult16_pkg::*;

    localparam int unsigned LAT    = 16;  // edges from accepting edge to edge raising done
    localparam int unsigned PERIOD = 18;  // edges between back-to-back accepts
    localparam int unsigned TMO    = 100;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [31:0] p;
        logic        ovf;
        int unsigned cyc;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    seq_mult16_if bus ();

    seq_mult16 u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          n_vec = 0;
    int          n_err = 0;
    exp_t        sb[$];
    exp_t        mon_e;
    logic        post_chk = 1'b0;
    logic [31:0] last_p   = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, want 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: plain integer product.
    function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
        exp_t e;
        e.a   = a;
        e.b   = b;
        e.p   = 32'(a) * 32'(b);
        e.ovf = (e.p[31:16] != 16'h0);
        e.cyc = 0;
        return e;
    endfunction

    // Monitor: pops an expectation on every done and checks the cycle after it.
    always @(negedge clk) begin
        if (rst_n) begin
            if (post_chk) begin
                chk("busy_after_done", 32'(bus.busy), 32'd0);
                chk("done_one_cycle", 32'(bus.done), 32'd0);
                chk("p_held", bus.p, last_p);
                post_chk = 1'b0;
            end
            if (bus.done) begin
                if (sb.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL unexpected_done: got done with p=0x%08h, want no done (t=%0t)",
                             bus.p, $time);
                end else begin
                    mon_e = sb.pop_front();
                    chk($sformatf("p %h*%h", mon_e.a, mon_e.b), bus.p, mon_e.p);
                    chk($sformatf("ovf %h*%h", mon_e.a, mon_e.b), 32'(bus.ovf), 32'(mon_e.ovf));
                    chk("latency", cyc - mon_e.cyc, LAT);
                    chk("busy_in_done", 32'(bus.busy), 32'd1);
                    last_p   = mon_e.p;
                    post_chk = 1'b1;
                end
            end
        end
    end

    task automatic issue_exp(input logic [15:0] a, input logic [15:0] b,
                             input logic [31:0] p, input logic ovf,
                             input bit keep, output int unsigned acc);
        int unsigned t = 0;
        exp_t        e;
        acc = 0;
        @(negedge clk);
        while (bus.busy && t < TMO) begin
            @(negedge clk);
            t++;
        end
        chk("idle_before_start", 32'(bus.busy), 32'd0);
        if (bus.busy) return;
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        e.a   = a;
        e.b   = b;
        e.p   = p;
        e.ovf = ovf;
        e.cyc = cyc;
        acc   = cyc;
        sb.push_back(e);
        if (!keep) bus.start = 1'b0;
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
    endtask

    task automatic issue(input logic [15:0] a, input logic [15:0] b,
                         input bit keep, output int unsigned acc);
        exp_t e;
        e = model(a, b);
        issue_exp(a, b, e.p, e.ovf, keep, acc);
    endtask

    task automatic drain();
        int unsigned t = 0;
        while (sb.size() != 0 && t < TMO) begin
            @(negedge clk);
            t++;
        end
        chk("drain", 32'(sb.size()), 32'd0);
        sb.delete();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation still running at t=%0t, want finished", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned acc;
        int unsigned prev_acc;
        logic [15:0] ra, rb;

        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;

        repeat (3) @(negedge clk);
        chk("reset_busy", 32'(bus.busy), 32'd0);
        chk("reset_done", 32'(bus.done), 32'd0);
        chk("reset_p", bus.p, 32'd0);
        chk("reset_ovf", 32'(bus.ovf), 32'd0);
        rst_n = 1'b1;

        // Directed products with hand-computed expectations.
        issue_exp(16'd3, 16'd5, 32'h0000_000F, 1'b0, 1'b0, acc);
        drain();
        issue_exp(16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b1, 1'b0, acc);
        drain();
        issue_exp(16'h0000, 16'h1234, 32'h0, 1'b0, 1'b0, acc);
        drain();
        issue_exp(16'hABCD, 16'h0000, 32'h0, 1'b0, 1'b0, acc);
        drain();
        issue_exp(16'h8000, 16'h0002, 32'h0001_0000, 1'b1, 1'b0, acc);
        drain();

        // Starts during CALC and DONE must be ignored.
        issue_exp(16'd7, 16'd9, 32'd63, 1'b0, 1'b0, acc);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            bus.a     = 16'd1;
            bus.b     = 16'd1;
            bus.start = (c == 5 || c == 16 || c == 17);
        end
        drain();
        issue_exp(16'd1, 16'd1, 32'd1, 1'b0, 1'b0, acc);
        drain();

        // Asynchronous reset in the middle of CALC discards the operation.
        issue(16'h1234, 16'h5678, 1'b0, acc);
        repeat (8) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        sb.delete();
        chk("midrst_busy", 32'(bus.busy), 32'd0);
        chk("midrst_done", 32'(bus.done), 32'd0);
        chk("midrst_p", bus.p, 32'd0);
        chk("midrst_ovf", 32'(bus.ovf), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        issue(16'h00FF, 16'h0101, 1'b0, acc);
        drain();

        // Held start: back-to-back operations at a fixed period.
        prev_acc = 0;
        for (int i = 0; i < 5; i++) begin
            issue(16'($urandom), 16'($urandom), 1'b1, acc);
            if (i > 0) chk("restart_period", acc - prev_acc, PERIOD);
            prev_acc = acc;
        end
        bus.start = 1'b0;
        drain();

        // Random operands, biased occasionally toward extreme values.
        for (int i = 0; i < 1000; i++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 7))
                0: ra = 16'hFFFF;
                1: rb = 16'hFFFF;
                2: ra = 16'h0000;
                3: rb = 16'h0001;
                default: ;
            endcase
            issue(ra, rb, 1'b0, acc);
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
